// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//
// Execute stage of a five-stage pipeline. It takes the fields of the ID/EX
// latch and does three things:
//   - runs the ALU, with operands selected through the forwarding muxes;
//   - resolves branches and jumps, and drives a combinational front-end
//     redirect when one is taken;
//   - registers the results into the EX/MEM latch.
// A sticky halt state drains the machine once a halt instruction is accepted.
//
// Ports
//   CLK, RST            clock; synchronous active-high reset
//   en                  EX/MEM load enable (low = memory stage stalled)
//   flush               load a bubble into EX/MEM
//   pc_plus_4, porta, rdat2, extout, jaddr   ID/EX data fields
//   ALUSrc .. JAL       ID/EX control fields
//   ALUop               ALU operation
//   Rd, Rt              destination register candidates
//   fwdA, fwdB          forward selects (0 latch, 1 mem_fwd, 2 wb_fwd, 3 latch)
//   mem_fwd, wb_fwd     forwarding data
//   redirect, redirect_pc   taken branch/jump and its target (combinational)
//   out_*               EX/MEM latch contents
// -----------------------------------------------------------------------------

package execute_stage_pkg;
    typedef logic [4:0] regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;
endpackage

module execute_stage
    import execute_stage_pkg::*;
#(
    parameter regbits_t RA_REG = 5'd31
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] pc_plus_4,
    input  logic [31:0] porta,
    input  logic [31:0] rdat2,
    input  logic [31:0] extout,
    input  logic [31:0] jaddr,
    input  logic        ALUSrc,
    input  logic        Branch,
    input  logic        bne,
    input  logic        regWEN,
    input  logic        halt,
    input  logic        Jump,
    input  logic        MemtoReg,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic        regDst,
    input  logic        JAL,
    input  aluop_t      ALUop,
    input  regbits_t    Rd,
    input  regbits_t    Rt,
    input  logic [1:0]  fwdA,
    input  logic [1:0]  fwdB,
    input  logic [31:0] mem_fwd,
    input  logic [31:0] wb_fwd,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] out_aluresult,
    output logic [31:0] out_wdat,
    output logic [31:0] out_pc_plus_4,
    output regbits_t    out_wsel,
    output logic        out_regWEN,
    output logic        out_MemtoReg,
    output logic        out_dREN,
    output logic        out_dWEN,
    output logic        out_JAL,
    output logic        out_halt
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t      state_q,        state_d;
    logic [31:0] aluresult_q,    aluresult_d;
    logic [31:0] wdat_q,         wdat_d;
    logic [31:0] pc_plus_4_q,    pc_plus_4_d;
    regbits_t    wsel_q,         wsel_d;
    logic        regwen_q,       regwen_d;
    logic        memtoreg_q,     memtoreg_d;
    logic        dren_q,         dren_d;
    logic        dwen_q,         dwen_d;
    logic        jal_q,          jal_d;
    logic        halt_q,         halt_d;

    logic        halted;
    assign halted = (state_q == ST_HALTED);

    // -------------------------------------------------------------------------
    // Operand selection. Select code 3 is unused and falls back to the
    // latched value so a stray encoding never picks up stale forward data.
    // -------------------------------------------------------------------------
    logic [31:0] opa;
    logic [31:0] opbf;
    logic [31:0] opb;

    always_comb begin
        opa = porta;
        case (fwdA)
            2'd1:    opa = mem_fwd;
            2'd2:    opa = wb_fwd;
            default: opa = porta;
        endcase
    end

    always_comb begin
        opbf = rdat2;
        case (fwdB)
            2'd1:    opbf = mem_fwd;
            2'd2:    opbf = wb_fwd;
            default: opbf = rdat2;
        endcase
    end

    // Store data always comes from the forwarded register operand, even when
    // the ALU itself is fed the immediate.
    assign opb = ALUSrc ? extout : opbf;

    // -------------------------------------------------------------------------
    // ALU
    // -------------------------------------------------------------------------
    logic [31:0] alu_result;
    logic [4:0]  shamt;
    logic        alu_zero;

    assign shamt = extout[10:6];

    always_comb begin
        alu_result = 32'd0;
        case (ALUop)
            ALU_SLL:  alu_result = opb << shamt;
            ALU_SRL:  alu_result = opb >> shamt;
            ALU_ADD:  alu_result = opa + opb;
            ALU_SUB:  alu_result = opa - opb;
            ALU_AND:  alu_result = opa & opb;
            ALU_OR:   alu_result = opa | opb;
            ALU_XOR:  alu_result = opa ^ opb;
            ALU_NOR:  alu_result = ~(opa | opb);
            ALU_SLT:  alu_result = {31'd0, ($signed(opa) < $signed(opb))};
            ALU_SLTU: alu_result = {31'd0, (opa < opb)};
            default:  alu_result = 32'd0;
        endcase
    end

    assign alu_zero = (alu_result == 32'd0);

    // -------------------------------------------------------------------------
    // Branch / jump resolution. The redirect is combinational so the hazard
    // unit can flush fetch and decode on the same edge. It is suppressed while
    // the EX/MEM latch is stalled, because the instruction has not yet moved
    // on; it will reassert once en returns high.
    // -------------------------------------------------------------------------
    logic        branch_taken;
    logic [31:0] branch_target;

    assign branch_taken  = Branch & (alu_zero ^ bne);
    assign branch_target = pc_plus_4 + {extout[29:0], 2'b00};

    assign redirect    = en & ~halted & (Jump | branch_taken);
    assign redirect_pc = Jump ? jaddr : branch_target;

    // -------------------------------------------------------------------------
    // Destination register select
    // -------------------------------------------------------------------------
    regbits_t wsel_calc;

    always_comb begin
        if (JAL) begin
            wsel_calc = RA_REG;
        end else if (regDst) begin
            wsel_calc = Rd;
        end else begin
            wsel_calc = Rt;
        end
    end

    // -------------------------------------------------------------------------
    // EX/MEM next-state: hold when stalled; bubble on flush or when halted;
    // otherwise load the computed values. A halt accepted without a flush
    // moves the FSM to HALTED and sets out_halt on the same edge.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        aluresult_d = aluresult_q;
        wdat_d      = wdat_q;
        pc_plus_4_d = pc_plus_4_q;
        wsel_d      = wsel_q;
        regwen_d    = regwen_q;
        memtoreg_d  = memtoreg_q;
        dren_d      = dren_q;
        dwen_d      = dwen_q;
        jal_d       = jal_q;
        halt_d      = halt_q;

        if (en) begin
            if (flush || halted) begin
                aluresult_d = 32'd0;
                wdat_d      = 32'd0;
                pc_plus_4_d = 32'd0;
                wsel_d      = '0;
                regwen_d    = 1'b0;
                memtoreg_d  = 1'b0;
                dren_d      = 1'b0;
                dwen_d      = 1'b0;
                jal_d       = 1'b0;
                halt_d      = halted;
            end else begin
                aluresult_d = alu_result;
                wdat_d      = opbf;
                pc_plus_4_d = pc_plus_4;
                wsel_d      = wsel_calc;
                regwen_d    = regWEN;
                memtoreg_d  = MemtoReg;
                dren_d      = dREN;
                dwen_d      = dWEN;
                jal_d       = JAL;
                halt_d      = halt;
                if (halt) begin
                    state_d = ST_HALTED;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_RUN;
            aluresult_q <= 32'd0;
            wdat_q      <= 32'd0;
            pc_plus_4_q <= 32'd0;
            wsel_q      <= '0;
            regwen_q    <= 1'b0;
            memtoreg_q  <= 1'b0;
            dren_q      <= 1'b0;
            dwen_q      <= 1'b0;
            jal_q       <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            aluresult_q <= aluresult_d;
            wdat_q      <= wdat_d;
            pc_plus_4_q <= pc_plus_4_d;
            wsel_q      <= wsel_d;
            regwen_q    <= regwen_d;
            memtoreg_q  <= memtoreg_d;
            dren_q      <= dren_d;
            dwen_q      <= dwen_d;
            jal_q       <= jal_d;
            halt_q      <= halt_d;
        end
    end

    assign out_aluresult = aluresult_q;
    assign out_wdat      = wdat_q;
    assign out_pc_plus_4 = pc_plus_4_q;
    assign out_wsel      = wsel_q;
    assign out_regWEN    = regwen_q;
    assign out_MemtoReg  = memtoreg_q;
    assign out_dREN      = dren_q;
    assign out_dWEN      = dwen_q;
    assign out_JAL       = jal_q;
    assign out_halt      = halt_q;

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage pipeline. It sits directly downstream of the ID/EX decode latch and consumes that latch's `out_*` fields. It performs the ALU operation and resolves branches and jumps, issuing a front-end redirect when one is taken. Results are registered into the EX/MEM latch that feeds the memory stage. A sticky halt state drains the machine once a halt instruction reaches execute.

## Interface
Parameters:
- `RA_REG`, default 5'd31, destination register for JAL.

Ports:
- `CLK`  in  1  — clock; single clock domain.
- `RST`  in  1  — reset; synchronous, active-high.
- `en`  in  1  — EX/MEM latch load enable; low means the memory stage is stalled.
- `flush`  in  1  — load a bubble into EX/MEM.
- `pc_plus_4, porta, rdat2, extout, jaddr`  in  32 each  — fields from the ID/EX latch.
- `ALUSrc, Branch, bne, regWEN, halt, Jump, MemtoReg, dREN, dWEN, regDst, JAL`  in  1 each  — control fields from the ID/EX latch.
- `ALUop`  in  aluop_t  — ALU operation.
- `Rd, Rt`  in  regbits_t  — destination candidates.
- `fwdA, fwdB`  in  2 each  — forward select: 0 = latch value, 1 = `mem_fwd`, 2 = `wb_fwd`, 3 = reserved (treated as 0).
- `mem_fwd, wb_fwd`  in  32 each  — forwarding data.
- `redirect`  out  1  — taken branch or jump; fetch loads `redirect_pc`.
- `redirect_pc`  out  32  — target address.
- `out_aluresult, out_wdat, out_pc_plus_4`  out  32 each  — EX/MEM data.
- `out_wsel`  out  regbits_t  — destination register.
- `out_regWEN, out_MemtoReg, out_dREN, out_dWEN, out_JAL, out_halt`  out  1 each  — EX/MEM control.

## Operation
- Operand A = forwarded `porta`.
- Operand Bf = forwarded `rdat2`. Operand B = `extout` if `ALUSrc` is set, otherwise Bf.
- ALU operations:
  - ADD and SUB are 32-bit two's-complement and wrap; overflow is ignored.
  - AND, OR, XOR and NOR are bitwise.
  - SLT compares signed and produces 1 or 0. SLTU compares unsigned and produces 1 or 0.
  - SLL and SRL shift B by `extout[10:6]`.
- `zero` = (ALU result == 0).
- Branch taken = `Branch & (zero ^ bne)`. Branch target = `pc_plus_4 + (extout << 2)`, truncated to 32 bits.
- Jump (J or JAL): target = `jaddr`.
- Jump has priority over branch if both are set.
- `redirect = en & ~halted & (Jump | taken)`. This output is combinational from the current ID/EX contents.
- `out_wsel`:
  - `RA_REG` if `JAL`;
  - else `Rd` if `regDst`;
  - else `Rt`.
- `out_wdat` = Bf, used as store data.
- `out_aluresult` = ALU result.
- `out_pc_plus_4` passes through; writeback uses it for JAL.
- EX/MEM latch update, in priority order:
  - `RST` clears all outputs and `halted`.
  - `en` low holds all outputs; `flush` is ignored.
  - `en` high with `flush` or `halted` loads a bubble: all control 0, all data 0, and `out_halt` = `halted`.
  - Otherwise the latch loads the computed values.
- Halt state machine with two states, RUN and HALTED:
  - RUN → HALTED when `en & halt & ~flush` at a clock edge; `out_halt` becomes 1 on that edge.
  - HALTED is left only by `RST`.
  - In HALTED, `redirect` = 0 and every load is a bubble with `out_halt` = 1.

## Timing
- Reset: every output is 0 and the state is RUN.
- Latency: ID/EX contents appear on the EX/MEM outputs one clock edge after `en` is high.
- `redirect` and `redirect_pc` are valid in the same cycle as the ID/EX contents. The hazard unit converts `redirect` into flushes of the fetch and decode latches on that same edge.
- `en` low for N cycles: the outputs are frozen for N cycles and `redirect` is held low. The redirect reasserts when `en` returns high while the instruction is still in ID/EX.
- Simultaneous `flush` and `halt` with `en` high: flush wins, the state remains RUN, and a bubble is loaded.
- `RST` asserted mid-stall or mid-halt: cleared at the next edge regardless of `en`.

## Test plan
- Reset: hold `RST` 2 cycles with random inputs → all outputs 0, `redirect` 0; `halt` is not latched.
- ADD with `porta`=32'hFFFFFFFF, `rdat2`=1, `ALUSrc`=0, `regDst`=1, `Rd`=5, `en`=1 → next edge: `out_aluresult`=0, `out_wsel`=5, `out_regWEN` as input. Then SLT with -1 vs 1 → 1; SLTU with the same operands → 0.
- BEQ with `porta`=`rdat2`=7, `pc_plus_4`=32'h104, `extout`=32'hFFFFFFFE → `redirect`=1, `redirect_pc`=32'hFC. The same case with `bne`=1 → `redirect`=0.
- Forwarding: `fwdA`=1, `mem_fwd`=10, `fwdB`=2, `wb_fwd`=3, SUB → `out_aluresult`=7. Then `ALUSrc`=1 with `extout`=4 and `fwdB`=2, SW → `out_wdat`=3.
- Stall and flush: load an instruction, then hold `en`=0 with `flush`=1 for 3 cycles → outputs unchanged and `redirect`=0. Then `en`=1 with `flush`=1 → bubble.
- Halt: `halt`=1 with `en`=1 → `out_halt`=1. Then a JAL with `en`=1 → `redirect`=0, `out_regWEN`=0, `out_halt` stays 1. Then `RST` → `out_halt`=0.
